// File: rtl/qr_pkg.sv
// Shared QR pipeline definitions: matrix geometry, row-bus width and loader state encoding.
// Used by the matrix loader and the CORDIC core so both agree on the row format.
package qr_pkg;

  localparam int QR_LENGTH = 13;
  localparam int QR_ROWS   = 8;
  localparam int QR_COLS   = 4;
  localparam int QR_ROW_W  = QR_COLS * QR_LENGTH;

  typedef logic [1:0] qr_state_t;

  localparam qr_state_t ST_FILL  = 2'd0;
  localparam qr_state_t ST_SEND  = 2'd1;
  localparam qr_state_t ST_WAIT  = 2'd2;
  localparam qr_state_t ST_DRAIN = 2'd3;

  typedef logic [QR_COLS-1:0][QR_LENGTH-1:0] qr_row_t;

endpackage

// File: rtl/qr_row_buf.sv
// Row buffer for one matrix: one element-wide write per cycle into (row, col),
// and an asynchronous read of a whole packed row (col c occupies bits [LENGTH*c +: LENGTH]).
module qr_row_buf
  import qr_pkg::*;
#(
  parameter int LENGTH = QR_LENGTH,
  parameter int ROWS   = QR_ROWS,
  parameter int COLS   = QR_COLS,
  parameter int RW     = 3,
  parameter int CW     = 2
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [RW-1:0]            wr_row,
  input  logic [CW-1:0]            wr_col,
  input  logic [LENGTH-1:0]        wr_data,
  input  logic [RW-1:0]            rd_row,
  output logic [COLS*LENGTH-1:0]   rd_data
);

  logic [COLS-1:0][LENGTH-1:0] mem_q [ROWS];

  // NOTE: storage has no reset; every entry is rewritten before it is read out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_row][wr_col] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_row];

endmodule

// File: rtl/qr_matrix_loader.sv
// Collects a ROWSxCOLS matrix element by element, streams its rows to the CORDIC core,
// then waits (with a watchdog) for and counts the ROWS result cycles before reloading.
module qr_matrix_loader
  import qr_pkg::*;
#(
  parameter int LENGTH = QR_LENGTH,
  parameter int ROWS   = QR_ROWS,
  parameter int COLS   = QR_COLS,
  parameter int WD_MAX = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   elem_valid,
  input  logic [LENGTH-1:0]      elem_data,
  output logic                   elem_ready,
  output logic                   cor_valid,
  output logic [COLS*LENGTH-1:0] cor_in,
  input  logic                   cor_out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int WW = (WD_MAX > 1) ? $clog2(WD_MAX) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(WD_MAX - 1);

  qr_state_t               state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [WW-1:0]           wd_q, wd_d;
  logic                    elem_ready_q, elem_ready_d;
  logic                    cor_valid_q, cor_valid_d;
  logic [COLS*LENGTH-1:0]  cor_in_q, cor_in_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    wr_en;
  logic [RW-1:0]           rd_row;
  logic [COLS*LENGTH-1:0]  rd_data;

  qr_row_buf #(
    .LENGTH (LENGTH),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .RW     (RW),
    .CW     (CW)
  ) u_row_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_row  (row_q),
    .wr_col  (col_q),
    .wr_data (elem_data),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  // row_q is the fill row, then the send beat index, then the result-row count.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    wd_d        = '0;
    cor_valid_d = 1'b0;
    cor_in_d    = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    rd_row      = '0;

    case (state_q)
      ST_FILL: begin
        if (elem_valid && elem_ready_q) begin
          wr_en = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              // Row 0 is already complete, so the first beat leaves on the same edge.
              row_d       = '0;
              state_d     = ST_SEND;
              cor_valid_d = 1'b1;
              cor_in_d    = rd_data;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = ST_WAIT;
        end else begin
          row_d       = row_q + 1'b1;
          rd_row      = row_q + 1'b1;
          cor_valid_d = 1'b1;
          cor_in_d    = rd_data;
        end
      end
      ST_WAIT: begin
        if (cor_out_valid) begin
          row_d   = RW'(1);
          state_d = ST_DRAIN;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FILL;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (row_q == ROW_LAST) begin
          done_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_FILL;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: begin
        row_d   = '0;
        col_d   = '0;
        state_d = ST_FILL;
      end
    endcase

    elem_ready_d = (state_d == ST_FILL);
    busy_d       = (state_d != ST_FILL);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      row_q        <= '0;
      col_q        <= '0;
      wd_q         <= '0;
      elem_ready_q <= 1'b0;
      cor_valid_q  <= 1'b0;
      cor_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wd_q         <= wd_d;
      elem_ready_q <= elem_ready_d;
      cor_valid_q  <= cor_valid_d;
      cor_in_q     <= cor_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign elem_ready = elem_ready_q;
  assign cor_valid  = cor_valid_q;
  assign cor_in     = cor_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_qr_matrix_loader.sv
// Directed-sequence bench for qr_matrix_loader; matrix contents are randomized and expected
// rows are packed from the list of accepted elements held in the bench.
module tb_qr_matrix_loader;

  localparam int LENGTH = 13;
  localparam int ROWS   = 8;
  localparam int COLS   = 4;
  localparam int WD_MAX = 1024;
  localparam int N_EL   = ROWS * COLS;
  localparam int ROW_W  = COLS * LENGTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              elem_valid;
  logic [LENGTH-1:0] elem_data;
  logic              elem_ready;
  logic              cor_valid;
  logic [ROW_W-1:0]  cor_in;
  logic              cor_out_valid;
  logic              busy;
  logic              done;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LENGTH-1:0] vals [N_EL];
  logic [ROW_W-1:0]  cap_rows [ROWS];

  qr_matrix_loader #(
    .LENGTH (LENGTH),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .WD_MAX (WD_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .elem_valid    (elem_valid),
    .elem_data     (elem_data),
    .elem_ready    (elem_ready),
    .cor_valid     (cor_valid),
    .cor_in        (cor_in),
    .cor_out_valid (cor_out_valid),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Element r*COLS+c lands in field c of row r.
  function automatic logic [ROW_W-1:0] exp_row(input int r);
    logic [ROW_W-1:0] row;
    row = '0;
    for (int c = 0; c < COLS; c++) row[c*LENGTH +: LENGTH] = vals[r*COLS + c];
    return row;
  endfunction

  task automatic junk();
    elem_valid = 1'b1;
    elem_data  = LENGTH'($urandom);
  endtask

  task automatic gen_random();
    for (int i = 0; i < N_EL; i++) vals[i] = LENGTH'($urandom);
  endtask

  // Feeds the 32 elements; ends at the first SEND beat.
  task automatic load(input bit toggle);
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (n < N_EL && guard < 2000) begin
      check("fill_ready_high", elem_ready, 1);
      elem_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      elem_data  = elem_valid ? vals[n] : LENGTH'($urandom);
      if (elem_valid) n++;
      tick();
      guard++;
    end
    check("fill_within_budget", 64'(n), 64'(N_EL));
    junk();
  endtask

  // Checks the 8 row beats (junk elements offered throughout); ends at WAIT cycle 1.
  task automatic check_send(input bit pulse_cov);
    for (int i = 0; i < ROWS; i++) begin
      check("send_valid", cor_valid, 1);
      check($sformatf("send_row%0d", i), cor_in, exp_row(i));
      check("send_ready_low", elem_ready, 0);
      check("send_busy", busy, 1);
      cap_rows[i] = cor_in;
      cor_out_valid = pulse_cov && (i == 2 || i == 7);
      junk();
      tick();
    end
    cor_out_valid = 1'b0;
    check("wait_valid_low", cor_valid, 0);
    check("wait_cor_in_zero", cor_in, 0);
  endtask

  // Result strobe on WAIT cycle k (cycle T); done must appear exactly at T+8.
  task automatic respond(input int k);
    for (int w = 1; w < k; w++) begin
      check("wait_no_done", done, 0);
      check("wait_ready_low", elem_ready, 0);
      check("wait_busy", busy, 1);
      junk();
      tick();
    end
    cor_out_valid = 1'b1;
    junk();
    tick();
    for (int j = 1; j < ROWS; j++) begin
      check("drain_no_early_done", done, 0);
      check("drain_ready_low", elem_ready, 0);
      cor_out_valid = (j == 3);
      junk();
      tick();
    end
    cor_out_valid = 1'b0;
    check("done_pulse", done, 1);
    check("ready_after_done", elem_ready, 1);
    check("idle_after_done", busy, 0);
    check("no_err_on_done", err, 0);
    elem_valid = 1'b0;
  endtask

  initial begin
    bit bad;
    rst           = 1'b1;
    elem_valid    = 1'b0;
    elem_data     = '0;
    cor_out_valid = 1'b0;
    repeat (3) tick();
    check("rst_ready", elem_ready, 0);
    check("rst_cor_valid", cor_valid, 0);
    check("rst_cor_in", cor_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", elem_ready, 1);

    // Back-to-back 1..32.
    for (int i = 0; i < N_EL; i++) vals[i] = LENGTH'(i + 1);
    load(1'b0);
    check_send(1'b0);
    check("row0_const", cap_rows[0], {13'd4, 13'd3, 13'd2, 13'd1});
    check("row7_const", cap_rows[7], {13'd32, 13'd31, 13'd30, 13'd29});
    respond(5);
    tick();
    check("done_one_cycle", done, 0);

    // 50% valid with negative extremes; strobes during SEND must be ignored.
    gen_random();
    vals[0]  = 13'h1000;
    vals[1]  = 13'h1FFF;
    vals[30] = 13'h1FFF;
    vals[31] = 13'h1000;
    load(1'b1);
    check_send(1'b1);
    check("neg_min_field", 64'(cap_rows[0][LENGTH-1:0]), 64'h1000);
    check("neg_one_field", 64'(cap_rows[0][2*LENGTH-1:LENGTH]), 64'h1FFF);
    respond(5);
    tick();

    // Watchdog: the 1024th WAIT cycle times out; its err pulse shows with the return to FILL.
    gen_random();
    load(1'b0);
    check_send(1'b0);
    bad = 1'b0;
    for (int w = 1; w <= WD_MAX; w++) begin
      if (err !== 1'b0 || done !== 1'b0 || elem_ready !== 1'b0) bad = 1'b1;
      junk();
      tick();
    end
    check("wd_quiet_before_timeout", bad, 0);
    check("wd_err_pulse", err, 1);
    check("wd_no_done", done, 0);
    check("wd_back_to_fill", elem_ready, 1);
    check("wd_idle", busy, 0);
    elem_valid = 1'b0;
    tick();
    check("wd_err_one_cycle", err, 0);

    // Reset on the 4th SEND beat, then a full matrix answered on the first WAIT cycle.
    gen_random();
    load(1'b0);
    for (int i = 0; i < 3; i++) begin
      check("pre_rst_send_valid", cor_valid, 1);
      tick();
    end
    check("beat4_row", cor_in, exp_row(3));
    rst = 1'b1;
    elem_valid = 1'b0;
    tick();
    check("abort_valid_low", cor_valid, 0);
    check("abort_cor_in_zero", cor_in, 0);
    check("abort_no_done", done, 0);
    rst = 1'b0;
    tick();
    check("abort_ready", elem_ready, 1);
    bad = 1'b0;
    repeat (10) begin
      if (done !== 1'b0 || cor_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    check("abort_quiet", bad, 0);
    gen_random();
    load(1'b1);
    check_send(1'b0);
    respond(1);
    tick();

    // Two matrices back-to-back; the second is offered from the cycle done appears.
    gen_random();
    load(1'b0);
    check_send(1'b0);
    respond(3);
    gen_random();
    load(1'b0);
    check_send(1'b0);
    respond(2);
    tick();
    check("final_done_low", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qr_matrix_loader.md
QR_MATRIX_LOADER -- requirements
Module: qr_matrix_loader

Interface
REQ-001 SHALL have parameter LENGTH, default 13: element width in bits (signed fixed point).
REQ-002 SHALL have parameter ROWS, default 8: rows per matrix.
REQ-003 SHALL have parameter COLS, default 4: columns per row; the row bus is COLS*LENGTH = 52 bits.
REQ-004 SHALL have parameter WD_MAX, default 1024: watchdog limit in cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port elem_valid, input, 1 bit: upstream element strobe.
REQ-008 SHALL have port elem_data, input, LENGTH bits: signed matrix element.
REQ-009 SHALL have port elem_ready, output, 1 bit: loader accepts elements.
REQ-010 SHALL have port cor_valid, output, 1 bit: drives the CORDIC core valid.
REQ-011 SHALL have port cor_in, output, 52 bits: drives the CORDIC core in.
REQ-012 SHALL have port cor_out_valid, input, 1 bit: driven by the CORDIC core out_vallid.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except FILL.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the result drain completes.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse on watchdog timeout.

Function
REQ-016 SHALL implement the states FILL, SEND, WAIT, DRAIN.
REQ-017 SHALL hold elem_ready = 1 in FILL only; an element transfers on any cycle with elem_valid && elem_ready.
REQ-018 SHALL store the element accepted at column c (0..3) into bits [13c+12:13c] of row buffer entry r (0..7); c increments per transfer and wraps 3->0 with r++ (row-major order).
REQ-019 SHALL register the 32nd transfer and enter SEND on the next edge, with elem_ready = 0 from that cycle on.
REQ-020 SHALL, in SEND, assert cor_valid for exactly ROWS consecutive cycles, presenting cor_in = buffer[0..7] in order, with no bubbles.
REQ-021 SHALL then enter WAIT with cor_valid = 0 and cor_in = 0.
REQ-022 SHALL, in WAIT, enter DRAIN on the first cor_out_valid = 1; that cycle counts as result row 1.
REQ-023 SHALL stay in DRAIN until ROWS result cycles total have elapsed, pulse done on the last, and return to FILL with the row and column counters zeroed.
REQ-024 SHALL ignore cor_out_valid in FILL, SEND and DRAIN.
REQ-025 SHALL count WAIT cycles with a watchdog; on reaching WD_MAX it pulses err for one cycle and returns to FILL without asserting done.
REQ-026 SHALL register all outputs; cor_valid and cor_in change only on rising clk.
REQ-027 SHALL pass elem_data bits unchanged, with no sign extension or rounding.

Reset
REQ-028 SHALL, while rst = 1 at a rising edge, set the state to FILL, zero the row, column and watchdog counters, and drive elem_ready = 0, cor_valid = 0, cor_in = 0, busy = 0, done = 0, err = 0.
REQ-029 SHALL drive elem_ready = 1 on the first cycle after rst deasserts.
REQ-030 SHALL leave row buffer contents undefined after reset; they are not reset.
REQ-031 SHALL, when reset is asserted mid-SEND or mid-DRAIN, abort immediately, with no further cor_valid beats and no done pulse.

Structure
REQ-032 SHALL take LENGTH, ROWS, COLS, the row-bus width and the state encoding from the shared package qr_pkg; the QR_CORDIC core uses the same package.
REQ-033 SHALL contain one sub-module, qr_row_buf: an 8x52 register file with a column-granular write port and one read port.
REQ-034 SHALL fit within 120-400 lines of RTL.

Verification
REQ-035 SHALL cover: reset, then 32 back-to-back elements with values 1..32 -> exactly 8 cor_valid cycles; row0 = {4,3,2,1}, row7 = {32,31,30,29}, each field 13 bits.
REQ-036 SHALL cover: elem_valid toggled 50% with negative values (-4096, -1) -> packing identical to the back-to-back case, two's-complement preserved, and no acceptance while elem_ready = 0.
REQ-037 SHALL cover: cor_out_valid pulsed during SEND -> ignored; pulsed in WAIT at cycle 5 -> done exactly 8 cycles after the first result cycle, then elem_ready = 1.
REQ-038 SHALL cover: cor_out_valid never asserted -> err pulses at WAIT cycle 1024, done never asserts, state returns to FILL.
REQ-039 SHALL cover: rst asserted on the 4th SEND beat -> cor_valid = 0 the next cycle, no done pulse; a following full matrix processes correctly.
REQ-040 SHALL cover: two matrices back-to-back -> the second matrix is accepted only after done, and its rows are not corrupted by the first matrix.
